// File: rtl/csi2_video_payload_gate_if.sv
// Packet-side bus of csi2_video_payload_gate: receiver headers/payload in, gated payload out.
// slave = gate view, master = upstream receiver / downstream consumer view.
interface csi2_video_payload_gate_if #(
   parameter int NUM_RX_LANE = 2,
   parameter int RX_GEAR     = 8
);
   localparam int DW  = NUM_RX_LANE * RX_GEAR;
   localparam int BPB = DW / 8;

   logic           sp_en_i;
   logic           lp_av_en_i;
   logic [5:0]     dt_i;
   logic [15:0]    wc_i;
   logic           payload_en_i;
   logic [DW-1:0]  payload_i;
   logic [DW-1:0]  payload_o;
   logic           payload_vld_o;
   logic           payload_last_o;
   logic [BPB-1:0] payload_keep_o;

   modport slave (
      input  sp_en_i, lp_av_en_i, dt_i, wc_i, payload_en_i, payload_i,
      output payload_o, payload_vld_o, payload_last_o, payload_keep_o
   );

   modport master (
      output sp_en_i, lp_av_en_i, dt_i, wc_i, payload_en_i, payload_i,
      input  payload_o, payload_vld_o, payload_last_o, payload_keep_o
   );
endinterface

// File: rtl/csi2_video_payload_gate.sv
// CSI-2 byte-clock packet qualifier: forwards video payload trimmed to word count, FS/FE markers.
// Optional macro CSI2_GATE_FRAME_ONLY_EN: drop (and flag) video lines arriving outside FS..FE.
module csi2_video_payload_gate #(
   parameter int         NUM_RX_LANE = 2,
   parameter int         RX_GEAR     = 8,
   parameter logic [5:0] VIDEO_DT    = 6'h2B
) (
   input  logic                        byte_clk,
   input  logic                        byte_clk_rst_n,
   csi2_video_payload_gate_if.slave    bus,
   input  logic                        clr_err_i,
   output logic                        sof_o,
   output logic                        eof_o,
   output logic                        frame_active_o,
   output logic [15:0]                 line_cnt_o,
   output logic                        short_line_err_o,
   output logic                        hdr_err_o
);
   localparam int          DW    = NUM_RX_LANE * RX_GEAR;
   localparam int          BPB   = DW / 8;
   localparam logic [15:0] BPB16 = 16'(BPB);
   localparam logic [5:0]  DT_FS = 6'h00;
   localparam logic [5:0]  DT_FE = 6'h01;

   typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

   state_t         r_state;
   logic [15:0]    r_rem;
   logic           r_seen;
   logic           r_pen_d;
   logic [DW-1:0]  r_payload;
   logic           r_vld;
   logic           r_last;
   logic [BPB-1:0] r_keep;
   logic           r_sof;
   logic           r_eof;
   logic           r_frame_active;
   logic [15:0]    r_line_cnt;
   logic           r_short_err;
   logic           r_hdr_err;

   logic w_video_hdr;
   logic w_frame_ok;
   logic w_hdr_evt;
   logic w_short_evt;

   function automatic logic [BPB-1:0] keep_mask(input logic [15:0] rem);
      logic [BPB-1:0] m;
      m = '0;
      for (int b = 0; b < BPB; b++) m[b] = (16'(b) < rem);
      return m;
   endfunction

   assign w_video_hdr = bus.lp_av_en_i && (bus.dt_i == VIDEO_DT);

`ifdef CSI2_GATE_FRAME_ONLY_EN
   assign w_frame_ok = r_frame_active;
`else
   assign w_frame_ok = 1'b1;
`endif

   // Header collisions: new header mid-line, short+long together, FS inside a frame, out-of-frame video.
   always_comb begin
      w_hdr_evt = ((bus.sp_en_i || bus.lp_av_en_i) && (r_state == PASS))
               || (bus.sp_en_i && bus.lp_av_en_i)
               || (bus.sp_en_i && (bus.dt_i == DT_FS) && r_frame_active)
               || (!bus.sp_en_i && w_video_hdr && !w_frame_ok);
      w_short_evt = !bus.sp_en_i && !bus.lp_av_en_i && (r_state == PASS)
                 && !bus.payload_en_i && r_seen;
   end

   always_ff @(posedge byte_clk or negedge byte_clk_rst_n) begin
      if (!byte_clk_rst_n) begin
         r_state        <= IDLE;
         r_rem          <= '0;
         r_seen         <= 1'b0;
         r_pen_d        <= 1'b0;
         r_payload      <= '0;
         r_vld          <= 1'b0;
         r_last         <= 1'b0;
         r_keep         <= '0;
         r_sof          <= 1'b0;
         r_eof          <= 1'b0;
         r_frame_active <= 1'b0;
         r_line_cnt     <= '0;
         r_short_err    <= 1'b0;
         r_hdr_err      <= 1'b0;
      end else begin
         r_payload   <= bus.payload_i;
         r_pen_d     <= bus.payload_en_i;
         r_vld       <= 1'b0;
         r_last      <= 1'b0;
         r_keep      <= '0;
         r_sof       <= 1'b0;
         r_eof       <= 1'b0;
         r_short_err <= (r_short_err && !clr_err_i) || w_short_evt;
         r_hdr_err   <= (r_hdr_err && !clr_err_i) || w_hdr_evt;

         if (bus.sp_en_i) begin
            r_state <= IDLE;
            r_seen  <= 1'b0;
            if (bus.dt_i == DT_FS) begin
               r_sof          <= 1'b1;
               r_frame_active <= 1'b1;
               r_line_cnt     <= '0;
            end else if (bus.dt_i == DT_FE) begin
               r_eof          <= 1'b1;
               r_frame_active <= 1'b0;
            end
         end else if (bus.lp_av_en_i) begin
            r_seen <= 1'b0;
            if (w_video_hdr && w_frame_ok) begin
               if (bus.wc_i != 16'd0) begin
                  r_state <= PASS;
                  r_rem   <= bus.wc_i;
               end else begin
                  r_state <= IDLE;
               end
            end else begin
               r_state <= DROP;
            end
         end else begin
            case (r_state)
               PASS: begin
                  if (bus.payload_en_i) begin
                     r_vld  <= 1'b1;
                     r_seen <= 1'b1;
                     if (r_rem <= BPB16) begin
                        r_last  <= 1'b1;
                        r_keep  <= keep_mask(r_rem);
                        r_state <= IDLE;
                        if (r_line_cnt != 16'hFFFF) r_line_cnt <= r_line_cnt + 16'd1;
                     end else begin
                        r_keep <= '1;
                        r_rem  <= r_rem - BPB16;
                     end
                  end else if (r_seen) begin
                     r_state <= IDLE;
                     r_seen  <= 1'b0;
                  end
               end
               DROP: begin
                  if (r_pen_d && !bus.payload_en_i) r_state <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.payload_o      = r_payload;
   assign bus.payload_vld_o  = r_vld;
   assign bus.payload_last_o = r_last;
   assign bus.payload_keep_o = r_keep;
   assign sof_o              = r_sof;
   assign eof_o              = r_eof;
   assign frame_active_o     = r_frame_active;
   assign line_cnt_o         = r_line_cnt;
   assign short_line_err_o   = r_short_err;
   assign hdr_err_o          = r_hdr_err;
endmodule
